// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-RAM arbiter.
// The command struct carries one accepted access from the grant cycle into the RAM cycle.
package mem_arb_pkg;

    localparam int DATA_W  = 32;
    localparam int WORD_AW = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef logic owner_t;

    typedef struct packed {
        logic              vld;
        owner_t            owner;
        logic              we;
        logic [31:0]       addr;
        logic [DATA_W-1:0] wdata;
        logic              err;
    } cmd_t;

    // Misaligned or beyond the 2**WORD_AW-word RAM.
    function automatic logic addrBad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr[31:WORD_AW+2] != '0);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester ports plus the RAM-side bus of the arbiter.
// The arbiter uses the slave view; requesters and the RAM model use the master view.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              p0_req;
    logic              p0_we;
    logic [31:0]       p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_err;

    logic              p1_req;
    logic              p1_we;
    logic [31:0]       p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_err;

    logic [31:0]       ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_MemRead;
    logic              ram_MemWrite;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  ram_rdata,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output ram_addr, ram_wdata, ram_MemRead, ram_MemWrite
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output ram_rdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  ram_addr, ram_wdata, ram_MemRead, ram_MemWrite
    );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker.
// With both ports requesting, the port that did not win last time gets the grant.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_t     lastOwner_i,
    output logic [1:0] gnt_o,
    output owner_t     winner_o
);

    always_comb begin
        winner_o = 1'b0;
        gnt_o    = 2'b00;
        case (req_i)
            2'b01:   winner_o = 1'b0;
            2'b10:   winner_o = 1'b1;
            2'b11:   winner_o = ~lastOwner_i;
            default: winner_o = 1'b0;
        endcase
        if (req_i != 2'b00) begin
            gnt_o = winner_o ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the single-port data RAM.
// Accept -> RAM access -> return pipeline, one new access per cycle.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    logic [1:0]        req;
    logic [1:0]        arbGnt;
    logic [1:0]        gnt;
    logic              accept;
    owner_t            winner;
    owner_t            lastOwner_q, lastOwner_d;
    cmd_t              cmd_q, cmd_d;
    state_t            state_q, state_d;
    logic              selWe;
    logic [31:0]       selAddr;
    logic [DATA_W-1:0] selWdata;
    logic              ramRead, ramWrite;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    assign req = {bus.p1_req, bus.p0_req};

    rr_arb2 uArb (
        .req_i       (req),
        .lastOwner_i (lastOwner_q),
        .gnt_o       (arbGnt),
        .winner_o    (winner)
    );

    // Grants are suppressed during reset so nothing is accepted on the release edge's far side.
    assign gnt         = arbGnt & {2{rst_n}};
    assign accept      = |gnt;
    assign bus.p0_gnt  = gnt[0];
    assign bus.p1_gnt  = gnt[1];

    always_comb begin
        selWe       = winner ? bus.p1_we    : bus.p0_we;
        selAddr     = winner ? bus.p1_addr  : bus.p0_addr;
        selWdata    = winner ? bus.p1_wdata : bus.p0_wdata;
        cmd_d       = cmd_q;
        cmd_d.vld   = 1'b0;
        lastOwner_d = lastOwner_q;
        if (accept) begin
            cmd_d.vld   = 1'b1;
            cmd_d.owner = winner;
            cmd_d.we    = selWe;
            cmd_d.addr  = selAddr;
            cmd_d.wdata = selWdata;
            cmd_d.err   = addrBad(selAddr);
            lastOwner_d = winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = accept ? ACCESS : IDLE;
            ACCESS:  state_d = accept ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from the state register so reset kills them immediately.
    always_comb begin
        ramRead  = 1'b0;
        ramWrite = 1'b0;
        if (state_q == ACCESS && !cmd_q.err) begin
            ramRead  = ~cmd_q.we;
            ramWrite = cmd_q.we;
        end
    end

    assign bus.ram_MemRead  = ramRead;
    assign bus.ram_MemWrite = ramWrite;
    assign bus.ram_addr     = cmd_q.addr;
    assign bus.ram_wdata    = cmd_q.wdata;

    always_comb begin
        rvalid_d = 2'b00;
        err_d    = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (cmd_q.vld) begin
            rvalid_d[cmd_q.owner] = 1'b1;
            err_d[cmd_q.owner]    = cmd_q.err;
            if (!cmd_q.err && !cmd_q.we) begin
                if (cmd_q.owner) begin
                    rdata1_d = bus.ram_rdata;
                end else begin
                    rdata0_d = bus.ram_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q       <= '0;
            lastOwner_q <= 1'b1;
            rvalid_q    <= 2'b00;
            err_q       <= 2'b00;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            cmd_q       <= cmd_d;
            lastOwner_q <= lastOwner_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign bus.p0_rvalid = rvalid_q[0];
    assign bus.p1_rvalid = rvalid_q[1];
    assign bus.p0_err    = err_q[0];
    assign bus.p1_err    = err_q[1];
    assign bus.p0_rdata  = rdata0_q;
    assign bus.p1_rdata  = rdata1_q;

endmodule
